// File: rtl/spi_reg_peripheral.sv
`timescale 1ns/1ps
// SPI mode-0 write-only register file: 16-bit frames {w, addr[6:0], data[7:0]} update five 8-bit registers.
// Latency: ncs rise to register update <= SYNC_STAGES+2 clk; no backpressure, malformed frames raise frame_err.
module spi_reg_peripheral #(
  parameter int SYNC_STAGES = 2,
  parameter int MAX_ADDR    = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       sclk,
  input  logic       copi,
  input  logic       ncs,
  output logic [7:0] en_reg_out_7_0,
  output logic [7:0] en_reg_out_15_8,
  output logic [7:0] en_reg_pwm_7_0,
  output logic [7:0] en_reg_pwm_15_8,
  output logic [7:0] pwm_duty_cycle,
  output logic       txn_done,
  output logic       frame_err
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SHIFT  = 2'd1,
    COMMIT = 2'd2
  } state_t;

  localparam logic [6:0] MAX_A   = 7'(MAX_ADDR);
  localparam logic [4:0] CNT_MAX = 5'd17;

  logic [SYNC_STAGES-1:0] sclk_sync;
  logic [SYNC_STAGES-1:0] copi_sync;
  logic [SYNC_STAGES-1:0] ncs_sync;
  logic [SYNC_STAGES-1:0] sync_fill;
  logic                   sclk_prev;
  logic                   ncs_prev;

  logic                   sclk_s;
  logic                   copi_s;
  logic                   ncs_s;
  logic                   sync_ok;
  logic                   sclk_rise;
  logic                   ncs_rise;

  state_t                 state;
  logic   [4:0]           bit_cnt;
  logic   [15:0]          shreg;
  logic                   armed;
  logic                   accept;

  always_ff @(posedge clk) begin
    if (rst) begin
      sclk_sync <= '0;
      copi_sync <= '0;
      ncs_sync  <= '1;
      sync_fill <= '0;
      sclk_prev <= 1'b0;
      ncs_prev  <= 1'b1;
    end else begin
      sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], sclk};
      copi_sync <= {copi_sync[SYNC_STAGES-2:0], copi};
      ncs_sync  <= {ncs_sync[SYNC_STAGES-2:0], ncs};
      sync_fill <= {sync_fill[SYNC_STAGES-2:0], 1'b1};
      sclk_prev <= sclk_sync[SYNC_STAGES-1];
      ncs_prev  <= ncs_sync[SYNC_STAGES-1];
    end
  end

  assign sclk_s    = sclk_sync[SYNC_STAGES-1];
  assign copi_s    = copi_sync[SYNC_STAGES-1];
  assign ncs_s     = ncs_sync[SYNC_STAGES-1];
  // ncs_s only reflects the pin once every stage has been refilled after reset
  assign sync_ok   = sync_fill[SYNC_STAGES-1];
  assign sclk_rise = sclk_s & ~sclk_prev;
  assign ncs_rise  = ncs_s & ~ncs_prev;

  assign accept = (bit_cnt == 5'd16) && shreg[15] && (shreg[14:8] <= MAX_A);

  always_ff @(posedge clk) begin
    if (rst) begin
      state           <= IDLE;
      bit_cnt         <= '0;
      shreg           <= '0;
      armed           <= 1'b0;
      txn_done        <= 1'b0;
      frame_err       <= 1'b0;
      en_reg_out_7_0  <= '0;
      en_reg_out_15_8 <= '0;
      en_reg_pwm_7_0  <= '0;
      en_reg_pwm_15_8 <= '0;
      pwm_duty_cycle  <= '0;
    end else begin
      txn_done  <= 1'b0;
      frame_err <= 1'b0;
      // A frame may only start after ncs has been seen high, so a frame
      // already running when reset releases is ignored; a low ncs seen
      // during COMMIT is still pending here and starts the next frame.
      if (sync_ok && ncs_s) begin
        armed <= 1'b1;
      end
      case (state)
        IDLE: begin
          if (armed && !ncs_s) begin
            state   <= SHIFT;
            bit_cnt <= '0;
            shreg   <= '0;
            armed   <= 1'b0;
          end
        end
        SHIFT: begin
          if (ncs_rise) begin
            state <= COMMIT;
          end else if (sclk_rise && !ncs_s) begin
            shreg <= {shreg[14:0], copi_s};
            if (bit_cnt != CNT_MAX) begin
              bit_cnt <= bit_cnt + 5'd1;
            end
          end
        end
        COMMIT: begin
          state <= IDLE;
          if (accept) begin
            txn_done <= 1'b1;
            case (shreg[14:8])
              7'd0:    en_reg_out_7_0  <= shreg[7:0];
              7'd1:    en_reg_out_15_8 <= shreg[7:0];
              7'd2:    en_reg_pwm_7_0  <= shreg[7:0];
              7'd3:    en_reg_pwm_15_8 <= shreg[7:0];
              7'd4:    pwm_duty_cycle  <= shreg[7:0];
              default: ;
            endcase
          end else begin
            frame_err <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
